// File: rtl/scff_chain_loader_if.sv
// Bitstream word stream into the scan-chain loader: din/din_last qualified by din_valid,
// accepted when din_ready is high on the same clock edge.
interface scff_chain_loader_if #(
  parameter int DW = 8
);
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_last;
  logic          din_ready;

  modport master (
    output din,
    output din_valid,
    output din_last,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    input  din_last,
    output din_ready
  );
endinterface

// File: rtl/scff_chain_loader.sv
// Shifts bitstream words LSB-first into the scff config chain and counts bits against CHAIN_LEN.
// One accept cycle per word, then one shift per bit; din_ready is high only while waiting for a word.
module scff_chain_loader #(
  parameter  int CHAIN_LEN = 256,
  parameter  int DW        = 8,
  localparam int CW        = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  scff_chain_loader_if.slave   din_if,
  output logic                 sc_di,
  output logic                 sc_shift,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CW-1:0]        bit_cnt
);

  localparam int WW = $clog2(DW + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  shreg_q, shreg_d;
  logic           last_q, last_d;
  logic [WW-1:0]  wi_q, wi_d;
  logic [CW-1:0]  bit_cnt_q, bit_cnt_d;

  logic [WW-1:0]  wi_inc;
  logic [CW-1:0]  cnt_inc;
  logic           din_rdy;

  assign wi_inc  = wi_q + 1'b1;
  assign cnt_inc = bit_cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    last_d    = last_q;
    wi_d      = wi_q;
    bit_cnt_d = bit_cnt_q;
    din_rdy   = 1'b0;
    sc_shift  = 1'b0;
    sc_di     = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d   = S_WAIT;
          bit_cnt_d = '0;
        end
      end

      S_WAIT: begin
        din_rdy = 1'b1;
        if (abort) begin
          state_d = S_IDLE;
        end else if (din_if.din_valid) begin
          shreg_d = din_if.din;
          last_d  = din_if.din_last;
          wi_d    = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        sc_shift = 1'b1;
        sc_di    = shreg_q[0];
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          shreg_d   = shreg_q >> 1;
          wi_d      = wi_inc;
          bit_cnt_d = cnt_inc;
          // Chain full wins over end-of-word: leftover word bits are dropped.
          if (cnt_inc == CW'(CHAIN_LEN)) begin
            state_d = last_q ? S_DONE : S_ERR;
          end else if (wi_inc == WW'(DW)) begin
            state_d = last_q ? S_ERR : S_WAIT;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      last_q    <= 1'b0;
      wi_q      <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      last_q    <= last_d;
      wi_q      <= wi_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign din_if.din_ready = din_rdy;
  assign busy    = (state_q == S_WAIT) || (state_q == S_SHIFT);
  assign done    = (state_q == S_DONE);
  assign err     = (state_q == S_ERR);
  assign bit_cnt = bit_cnt_q;

endmodule
